// File: rtl/uart_rx_if.sv
// Consumer-side bus of the UART receiver: byte handshake, error pulses,
// busy flag and a debug view of the receiver FSM state.
//
// Handshake: a byte moves from master to slave on every rising clk edge
// where rx_valid and rx_ready are both 1. The master holds rx_data stable
// while rx_valid is 1 and drops rx_valid after the transfer unless a new
// byte is loaded on that same edge. rx_ready while rx_valid is 0 has no
// effect.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;
    logic [2:0] fsm_state;

    // Receiver side: produces bytes and status.
    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output parity_err,
        output busy,
        output fsm_state,
        input  rx_ready
    );

    // Byte-consumer side.
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  parity_err,
        input  busy,
        input  fsm_state,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, with its own oversampling tick divider.
// Bytes leave over a valid/ready handshake; framing and overrun errors are
// reported as one-cycle pulses.
//
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit
// between the data bits and the stop bit; parity_err then pulses alongside
// the delivered byte. Without it the frame is plain 8N1 and parity_err is 0.
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd,
    uart_rx_if.master bus
);

    // Clocks per sample tick; truncation only skews the bit period slightly.
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TC_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    // Start bit is checked half a bit in; every later bit one full bit on.
    localparam logic [TC_W-1:0]  T_MID    = TC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TC_W-1:0]  T_END    = TC_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer. Flops reset to 1 so a reset never looks like a
    // start bit.
    // ------------------------------------------------------------------
    logic rxd_meta;
    logic rxs;

    // Two-flop synchronizer for the asynchronous rxd pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxs      <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxs      <= rxd_meta;
        end
    end

    // ------------------------------------------------------------------
    // Free-running sample tick divider; runs in every FSM state so the
    // start-bit search in IDLE uses the same tick grid as the data bits.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_cnt;
    logic             samp_tick;

    assign samp_tick = (div_cnt == DIV_LAST);

    // Divider counter 0..DIV-1, wrapping on samp_tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (samp_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM with its tick/bit counters and shift register.
    // ------------------------------------------------------------------
    state_t          state, state_n;
    logic [TC_W-1:0] tcnt, tcnt_n;
    logic [2:0]      bcnt, bcnt_n;
    logic [7:0]      shreg, shreg_n;
    logic            frame_done;   // good stop bit sampled this cycle
    logic            frame_bad;    // stop bit sampled low this cycle
`ifdef UART_RX_PARITY_EN
    logic            par_bit, par_bit_n;
`endif

    // FSM state and receive datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tcnt    <= '0;
            bcnt    <= '0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            tcnt    <= tcnt_n;
            bcnt    <= bcnt_n;
            shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
            par_bit <= par_bit_n;
`endif
        end
    end

    // Next-state, counter and sampling decisions; all advance on samp_tick only.
    always_comb begin
        state_n    = state;
        tcnt_n     = tcnt;
        bcnt_n     = bcnt;
        shreg_n    = shreg;
        frame_done = 1'b0;
        frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n  = par_bit;
`endif
        if (samp_tick) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_n = START;
                        tcnt_n  = '0;
                    end
                end

                START: begin
                    if (tcnt == T_MID) begin
                        if (rxs) begin
                            // Line went back high: a glitch, not a start bit.
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                            tcnt_n  = '0;
                            bcnt_n  = '0;
                        end
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end

                DATA: begin
                    if (tcnt == T_END) begin
                        // LSB arrives first, so shifting right lands it in bit 0.
                        shreg_n = {rxs, shreg[7:1]};
                        tcnt_n  = '0;
                        if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bcnt_n = bcnt + 3'd1;
                        end
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tcnt == T_END) begin
                        par_bit_n = rxs;
                        tcnt_n    = '0;
                        state_n   = STOP;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (tcnt == T_END) begin
                        tcnt_n = '0;
                        if (rxs) begin
                            frame_done = 1'b1;
                            state_n    = IDLE;
                        end else begin
                            // Hold off until the line idles so a break does
                            // not immediately look like another start bit.
                            frame_bad = 1'b1;
                            state_n   = BREAK_WAIT;
                        end
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end

                BREAK_WAIT: begin
                    if (rxs) begin
                        state_n = IDLE;
                    end
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register and handshake. A completed frame is loaded if the
    // holding register is empty or being drained on this same edge;
    // otherwise the new byte is dropped and overrun pulses.
    // ------------------------------------------------------------------
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       frame_err_q;
    logic       overrun_q;
    logic       out_free;

    assign out_free = !rx_valid_q || bus.rx_ready;

    // Holding register, valid flag and one-cycle error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_bad;
            overrun_q   <= 1'b0;
            if (frame_done) begin
                if (out_free) begin
                    rx_data_q  <= shreg;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    // Even parity: data bits plus parity bit must XOR to 0. Only checked on
    // a good stop bit, so a framing error masks it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= frame_done && (^{shreg, par_bit});
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state != IDLE);
    assign bus.fsm_state = state;

endmodule
